// File: rtl/scroll_display_pkg.sv
// Shared constants for the scrolling 7-segment driver: the message contents,
// the blank pattern and the active-low hex-to-segment table ({a,b,c,d,e,f,g}).
package scroll_display_pkg;

    localparam int MSG_LEN_DEFAULT = 16;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Message shown through the 4-character window, index 0 first.
    localparam logic [3:0] MSG [MSG_LEN_DEFAULT] = '{
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
    };

    // Active-low segment patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Character at a message position; positions beyond the stored table repeat it.
    function automatic logic [3:0] msg_char(input int unsigned idx);
        return MSG[idx % MSG_LEN_DEFAULT];
    endfunction

    // Active-low anode pattern with only the selected digit enabled.
    function automatic logic [3:0] anode_mask(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/scroll_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module hex_to_seg
    import scroll_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/scroll_display_driver.sv
// Scrolling 4-digit common-anode display driver.
// Scans the four digits round-robin and shows a window of the message that
// moves one character left on each rising edge of the debounced button.
// Optional build macro SCROLL_DISPLAY_AUTO_SCROLL_EN adds a periodic
// auto-scroll tick that advances the window like a press.
module scroll_display_driver
    import scroll_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int MSG_LEN        = 16,
    parameter int AUTO_CYCLES    = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PTR_W = $clog2(MSG_LEN);
    localparam int REF_W = $clog2(REFRESH_CYCLES);

    // Reject configurations the scan and wrap logic cannot handle.
    if (REFRESH_CYCLES < 2 || MSG_LEN < 4 || (MSG_LEN & (MSG_LEN - 1)) != 0 || AUTO_CYCLES < 1)
    begin : g_bad_params
        $error("scroll_display_driver: illegal parameter set");
    end

    logic             button_q;
    logic [PTR_W-1:0] ptr;
    logic [REF_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic             press;
    logic             advance;
    logic [PTR_W-1:0] char_idx;
    logic [3:0]       char_nib;
    logic [6:0]       seg_next;

    // A press is the first cycle the button is seen high.
    assign press = button_in & ~button_q;

`ifdef SCROLL_DISPLAY_AUTO_SCROLL_EN
    localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

    logic [AUTO_W-1:0] auto_cnt;
    logic              tick;

    assign tick    = (auto_cnt == AUTO_W'(AUTO_CYCLES - 1));
    // A press and a tick in the same cycle merge into a single step.
    assign advance = press | tick;

    // Auto-scroll period counter, restarted by any advance of the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (press || tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end
`else
    assign advance = press;
`endif

    // Edge-detect history, window pointer and digit scan state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            button_q    <= 1'b0;
            ptr         <= '0;
            refresh_cnt <= '0;
            digit_idx   <= 2'd3;
        end else begin
            button_q <= button_in;
            if (advance) begin
                ptr <= ptr + 1'b1;
            end
            if (refresh_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx - 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    // Leftmost digit (3) shows ptr, each digit to its right the next character.
    assign char_idx = ptr + PTR_W'(2'd3 - digit_idx);
    assign char_nib = msg_char(32'(char_idx));

    hex_to_seg u_hex_to_seg (
        .hex (char_nib),
        .seg (seg_next)
    );

    // Register the pin drivers so the anodes and segments change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anode_mask(digit_idx);
            seg <= seg_next;
            dp  <= (char_idx != '0);
        end
    end

endmodule

// File: tb/tb_scroll_display_driver.sv
// Self-checking bench for scroll_display_driver: a fixed vector table after
// reset, hand-written press/wrap/reset sequences, then random button traffic,
// all compared against a window/scan reference model.
module tb_scroll_display_driver;

    localparam int REFRESH = 4;
    localparam int MSG_N   = 16;
    localparam int AUTO    = 10;

`ifdef SCROLL_DISPLAY_AUTO_SCROLL_EN
    // The first auto tick moves the window at edge 10; fixed vectors stop there.
    localparam int VEC_CHECKED = 10;
`else
    localparam int VEC_CHECKED = 16;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       button_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    scroll_display_driver #(
        .REFRESH_CYCLES (REFRESH),
        .MSG_LEN        (MSG_N),
        .AUTO_CYCLES    (AUTO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button_in (button_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    typedef struct {
        logic       btn;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t       vecs [16];
    logic [6:0] seg_ref [16];

    int checks = 0;
    int passed = 0;

    // Reference model: window start, edges since reset release, auto period.
    int         m_ptr;
    int         m_edges;
    int         m_auto;
    logic       m_btn_prev;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    // Last pattern seen on each digit position.
    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr      = 0;
        m_edges    = 0;
        m_auto     = 0;
        m_btn_prev = 1'b0;
        exp_an     = 4'b1111;
        exp_seg    = 7'b1111111;
        exp_dp     = 1'b1;
    endtask

    // One clock edge: display follows the state before the edge, then the window moves.
    task automatic model_edge(input logic btn);
        int digit;
        int ch;
        bit press;
        bit tick;
        digit = 3 - ((m_edges / REFRESH) % 4);
        ch    = (m_ptr + 3 - digit) % MSG_N;
        exp_an        = 4'b1111;
        exp_an[digit] = 1'b0;
        exp_seg       = seg_ref[ch % 16];
        exp_dp        = (ch != 0);
        press = btn && !m_btn_prev;
`ifdef SCROLL_DISPLAY_AUTO_SCROLL_EN
        tick = (m_auto == AUTO - 1);
`else
        tick = 1'b0;
`endif
        if (press || tick) m_ptr = (m_ptr + 1) % MSG_N;
        m_auto     = (press || tick) ? 0 : m_auto + 1;
        m_btn_prev = btn;
        m_edges++;
    endtask

    task automatic compare_outputs();
        check("an", an, exp_an);
        check("seg", seg, exp_seg);
        check("dp", dp, exp_dp);
        check("one_anode_low", $countones(~an), 1);
        for (int k = 0; k < 4; k++) begin
            if (an[k] == 1'b0) begin
                cap_seg[k] = seg;
                cap_dp[k]  = dp;
            end
        end
    endtask

    task automatic cycle(input logic btn);
        button_in = btn;
        @(posedge clk);
        model_edge(btn);
        #1;
        compare_outputs();
    endtask

    task automatic press_once();
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
    endtask

    task automatic clear_capture();
        for (int k = 0; k < 4; k++) begin
            cap_seg[k] = 'x;
            cap_dp[k]  = 1'bx;
        end
    endtask

    // Asserts reset between edges and checks the pins blank without a clock edge.
    task automatic apply_reset();
        button_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_an", an, 4'b1111);
        check("async_reset_seg", seg, 7'b1111111);
        check("async_reset_dp", dp, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic btn;
        logic [3:0] ph_an  [4];
        logic [6:0] ph_seg [4];
        logic       ph_dp  [4];

        seg_ref = '{
            7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
        };

        // Expected scan after reset with no press: each digit lit for 4 edges.
        ph_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        ph_seg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
        ph_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 4; j++)
                vecs[p * 4 + j] = '{1'b0, ph_an[p], ph_seg[p], ph_dp[p]};

        clear_capture();
        apply_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].btn);
            if (i < VEC_CHECKED) begin
                check("vec_an", an, vecs[i].an);
                check("vec_seg", seg, vecs[i].seg);
                check("vec_dp", dp, vecs[i].dp);
            end
        end

`ifndef SCROLL_DISPLAY_AUTO_SCROLL_EN
        // Button held for 20 cycles advances the window once.
        for (int i = 0; i < 20; i++) cycle(1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        clear_capture();
        for (int i = 0; i < 16; i++) cycle(1'b0);
        check("held_press_left_char", cap_seg[3], 7'b1001111);
        check("held_press_no_dp", {cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}, 4'b1111);

        // Fourteen more presses: window starts at F, message start on digit 2.
        for (int i = 0; i < 14; i++) press_once();
        clear_capture();
        for (int i = 0; i < 16; i++) cycle(1'b0);
        check("ptr15_digit3", cap_seg[3], 7'b0111000);
        check("ptr15_digit2", cap_seg[2], 7'b0000001);
        check("ptr15_digit1", cap_seg[1], 7'b1001111);
        check("ptr15_digit0", cap_seg[0], 7'b0010010);
        check("ptr15_dp", {cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}, 4'b1011);

        // Sixteenth press wraps back to the message start.
        press_once();
        clear_capture();
        for (int i = 0; i < 16; i++) cycle(1'b0);
        check("wrap_digit3", cap_seg[3], 7'b0000001);
        check("wrap_dp", {cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}, 4'b0111);

        for (int i = 0; i < 5; i++) press_once();
`else
        // Free-running auto scroll with the button idle.
        for (int i = 0; i < 40; i++) cycle(1'b0);

        // Land a press on the same edge as an auto tick; the model allows +1 only.
        for (int g = 0; g < 2 * AUTO && m_auto != AUTO - 1; g++) cycle(1'b0);
        check("coincident_alignment", m_auto, AUTO - 1);
        cycle(1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0);

        // Bring the window to 5 before the mid-dwell reset.
        for (int g = 0; g < 40 && m_ptr != 5; g++) press_once();
`endif

        // Reset in the middle of a dwell, then restart from character 0.
        cycle(1'b0);
        cycle(1'b0);
        apply_reset();
        cycle(1'b0);
        check("restart_an", an, 4'b0111);
        check("restart_seg", seg, 7'b0000001);
        check("restart_dp", dp, 1'b0);

        // Random button traffic with random hold lengths.
        btn = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            cycle(btn);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
